mux2_8_arbiter: RTL and testbench
=================================

# mux2_8_arbiter

- Round-robin arbiter and sequencer for the shared 8-bit 2:1 mux datapath (d0/d1 → y, select s).
- Two requesters each present a data word with a request. The block picks one, drives the mux select, captures the selected word into an output register, and offers it downstream on a valid/ready handshake.
- It sits between the two data producers and the single consumer of the mux output, replacing a free-running select input.

## Interface
- WIDTH, 8, data width of d0/d1/y.
- HOLD_MAX, 4, max consecutive beats one requester may own the mux while the other is requesting; range 1–15.
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 has a valid word on d0.
- d0  in  WIDTH  requester 0 data.
- gnt0  out  1  combinational; high in the cycle d0 is captured.
- req1  in  1  requester 1 has a valid word on d1.
- d1  in  WIDTH  requester 1 data.
- gnt1  out  1  combinational; high in the cycle d1 is captured.
- s  out  1  current mux select (0 = d0, 1 = d1), registered.
- y  out  WIDTH  output register.
- y_valid  out  1  y holds an unconsumed word.
- y_ready  in  1  consumer accepts y when high with y_valid.
- cnt0, cnt1  out  16  beat counters per requester (see Configuration).

## Operation
- **States:** IDLE, OWN0, OWN1.
  - `last` bit records the most recently served requester.
  - `hold` counter (4 bit) counts consecutive beats in the current OWN state.
- **Slot free:** `slot = !y_valid || y_ready`.
- **Accept:** when slot is free and the selected requester has req high, that requester's gnt is high.
  - At the edge: y ← selected data, y_valid ← 1, gnt clears the word.
  - Requesters hold req and data stable until they sample gnt high at a rising edge.
- **IDLE:**
  - Only req0 → OWN0 and accept d0 the same cycle.
  - Only req1 → OWN1 and accept d1 the same cycle.
  - Both → serve `!last`.
  - Neither → stay.
- **OWNx, accepting a beat:**
  - hold increments.
  - If reqx stays high and (other req low or hold < HOLD_MAX), remain in OWNx.
  - If the other requester is requesting and hold reaches HOLD_MAX, switch to OWN(other), hold ← 0, `last` ← x.
- **OWNx, reqx drops:**
  - Other req high → switch to OWN(other) and serve it in that same cycle if slot is free.
  - Otherwise → IDLE, `last` ← x, hold ← 0.
- **s:** s equals the owner of the word captured in y; s updates at the same edge as y.
- **Drain without refill:** y_valid ← 0 when y_ready is high and no new accept occurs.
- **Backpressure:** y_ready low with y_valid high → no gnt, y/s/state/hold frozen.
- **Never:** gnt0 and gnt1 both high in the same cycle.

## Timing
- **Reset (synchronous, at the edge with reset high):**
  - y=0, y_valid=0, s=0, state=IDLE, hold=0, last=1 (requester 0 wins first tie), cnt0=cnt1=0.
  - gnt0=gnt1=0 while reset is high.
- **Latency:** req high with slot free at cycle N → gnt high in cycle N → y/y_valid/s updated after edge N.
- **Throughput:** one beat per cycle with y_ready held high; no bubble on owner switch.
- **Simultaneous drain and refill:** y_valid && y_ready && accept in the same cycle → y replaced, y_valid stays 1.
- **Reset mid-operation:** any pending y is discarded; no gnt is issued in the reset cycle.

## Configuration
- **MUX2_8_ARB_STATS_EN defined:**
  - cnt0/cnt1 increment on each gnt0/gnt1 edge.
  - 16-bit, saturating at 0xFFFF, cleared by reset.
- **Not defined:** counter logic is omitted; cnt0 and cnt1 are tied to 0.

## Test plan
- **Single requester:** reset, then req1=1 with d1=0xA5, y_ready=1.
  - gnt1 high in the first cycle; next cycle y=0xA5, s=1, y_valid=1.
  - Reset values checked first.
- **Tie:** both req high from IDLE after reset, d0=0x11, d1=0x22, HOLD_MAX=4.
  - y sequence 0x11×4, 0x22×4, 0x11×4…
  - s toggles every 4 beats; no idle cycles.
- **Backpressure:** y holds 0x3C, y_ready=0 for 5 cycles with both req high.
  - No gnt; y=0x3C and s stable.
  - y_ready=1 → drain and refill in the same cycle.
- **Owner drops:** OWN0, req0 falls after 2 beats while req1 is high.
  - Next beat from d1 with no bubble; hold restarts at 0.
- **Reset mid-burst:** reset asserted while y_valid=1 in OWN1.
  - Next cycle y=0, y_valid=0, state IDLE.
  - A subsequent tie serves requester 0 first.
- **Stats:** with MUX2_8_ARB_STATS_EN, after 6 beats from requester 0 and 3 from requester 1, cnt0=6 and cnt1=3.
  - Without the macro, cnt0 and cnt1 read 0 throughout.

Source files
------------

// File: rtl/mux2_8_arbiter.sv
// mux2_8_arbiter: round-robin arbiter/sequencer in front of a shared 2:1 mux.
// Two requesters (req0/d0, req1/d1) compete for one registered output y
// offered downstream on a valid/ready handshake. The owner keeps the mux for
// up to HOLD_MAX consecutive beats while the other side is waiting.
// Optional feature macro: MUX2_8_ARB_STATS_EN enables the per-requester
// saturating beat counters cnt0/cnt1 (tied to 0 otherwise).
module mux2_8_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     st, st_nxt;
  logic       last, last_nxt;
  logic [3:0] hold, hold_nxt;
  logic       slot, acc, sel, sel_vld;
  logic       own_hit, other_req, owner_req;
  logic [3:0] run;

  // Output slot is free when empty or being drained this cycle.
  assign slot = !y_valid || y_ready;

  // Pick the requester to serve: owner first, else the other; ties from IDLE go to !last.
  always_comb begin
    sel_vld = 1'b0;
    sel     = 1'b0;
    case (st)
      IDLE: begin
        if (req0 && req1) begin sel_vld = 1'b1; sel = !last; end
        else if (req0)    begin sel_vld = 1'b1; sel = 1'b0;  end
        else if (req1)    begin sel_vld = 1'b1; sel = 1'b1;  end
      end
      OWN0: begin
        if (req0)      begin sel_vld = 1'b1; sel = 1'b0; end
        else if (req1) begin sel_vld = 1'b1; sel = 1'b1; end
      end
      OWN1: begin
        if (req1)      begin sel_vld = 1'b1; sel = 1'b1; end
        else if (req0) begin sel_vld = 1'b1; sel = 1'b0; end
      end
      default: ;
    endcase
  end

  // A beat is accepted only with a free slot and never during reset.
  assign acc  = slot && sel_vld && !reset;
  assign gnt0 = acc && !sel;
  assign gnt1 = acc && sel;

  // Next state, hold count and last-served tracking.
  always_comb begin
    st_nxt    = st;
    hold_nxt  = hold;
    last_nxt  = last;
    own_hit   = (st == OWN0 && !sel) || (st == OWN1 && sel);
    run       = own_hit ? ((hold == 4'hF) ? 4'hF : hold + 4'd1) : 4'd1;
    other_req = sel ? req0 : req1;
    owner_req = (st == OWN1) ? req1 : req0;
    if (acc) begin
      last_nxt = sel;
      if (other_req && run >= HOLD_LIM) begin
        // Burst quota used up and the other side is waiting: hand over.
        st_nxt   = sel ? OWN0 : OWN1;
        hold_nxt = 4'd0;
      end else begin
        st_nxt   = sel ? OWN1 : OWN0;
        hold_nxt = run;
      end
    end else if (st != IDLE && !owner_req) begin
      // Owner went quiet without a beat being taken (slot blocked or nobody left).
      hold_nxt = 4'd0;
      if (sel_vld) begin
        st_nxt = sel ? OWN1 : OWN0;
      end else begin
        st_nxt   = IDLE;
        last_nxt = (st == OWN1);
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= IDLE;
      hold <= 4'd0;
      last <= 1'b1;
    end else begin
      st   <= st_nxt;
      hold <= hold_nxt;
      last <= last_nxt;
    end
  end

  // Output register: capture on accept, drop valid on drain without refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      s       <= 1'b0;
    end else if (acc) begin
      y       <= sel ? d1 : d0;
      y_valid <= 1'b1;
      s       <= sel;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

`ifdef MUX2_8_ARB_STATS_EN
  // Saturating per-requester beat counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (gnt1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  end
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mux2_8_arbiter.sv
// Bench for mux2_8_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural owner/run-length model.
module tb_mux2_8_arbiter;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, y_ready = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       gnt0, gnt1, s, y_valid;
  logic [7:0] y;
  logic [15:0] cnt0, cnt1;

  int nchk = 0, nerr = 0;

  // Reference model state: owner -1 = nobody, run = beats in current ownership.
  int         m_own, m_run, m_last, m_gnt;
  logic       m_yv, m_s;
  logic [7:0] m_y;
  int         m_c0, m_c1;

  mux2_8_arbiter #(.WIDTH(8), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .d0(d0), .gnt0(gnt0),
    .req1(req1), .d1(d1), .gnt1(gnt1),
    .s(s), .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int c);
`ifdef MUX2_8_ARB_STATS_EN
    return 16'(c);
`else
    return 16'(0 * c);
`endif
  endfunction

  task automatic model_reset();
    m_own = -1; m_run = 0; m_last = 1; m_gnt = -1;
    m_yv = 1'b0; m_s = 1'b0; m_y = '0; m_c0 = 0; m_c1 = 0;
  endtask

  task automatic post_checks();
    chk("y", 32'(y), 32'(m_y));
    chk("y_valid", 32'(y_valid), 32'(m_yv));
    chk("s", 32'(s), 32'(m_s));
    chk("cnt0", 32'(cnt0), 32'(exp_cnt(m_c0)));
    chk("cnt1", 32'(cnt1), 32'(exp_cnt(m_c1)));
  endtask

  // One clock: apply inputs, check grants mid-cycle, advance model, check registers.
  task automatic step(input logic r0, input logic [7:0] a0, input logic r1,
                      input logic [7:0] a1, input logic rdy);
    bit rq[2];
    int who, run;
    bit slot;
    req0 = r0; d0 = a0; req1 = r1; d1 = a1; y_ready = rdy;
    #4;
    rq[0] = r0; rq[1] = r1;
    slot = !m_yv || rdy;
    if (m_own < 0) who = (r0 && r1) ? (m_last == 1 ? 0 : 1) : r0 ? 0 : r1 ? 1 : -1;
    else if (rq[m_own]) who = m_own;
    else if (rq[1-m_own]) who = 1 - m_own;
    else who = -1;
    m_gnt = (slot && who >= 0) ? who : -1;
    chk("gnt0", 32'(gnt0), 32'(m_gnt == 0));
    chk("gnt1", 32'(gnt1), 32'(m_gnt == 1));
    if (m_gnt >= 0) begin
      run = (who == m_own) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
      m_last = who;
      if (rq[1-who] && run >= HOLD) begin m_own = 1 - who; m_run = 0; end
      else begin m_own = who; m_run = run; end
      m_y = who ? a1 : a0; m_yv = 1'b1; m_s = who[0];
      if (who == 0) m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
      else          m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
    end else begin
      if (rdy) m_yv = 1'b0;
      if (m_own >= 0 && !rq[m_own]) begin
        if (rq[1-m_own]) begin m_own = 1 - m_own; m_run = 0; end
        else begin m_last = m_own; m_own = -1; m_run = 0; end
      end
    end
    @(posedge clk); #1;
    post_checks();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #4;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    post_checks();
  endtask

  initial begin
    logic       pr0, pr1;
    logic [7:0] pd0, pd1;
    model_reset();
    @(posedge clk); #1;

    // Reset values, then a single requester.
    do_reset();
    step(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1);
    chk("single_y", 32'(y), 32'hA5);
    chk("single_s", 32'(s), 32'd1);

    // Tie from IDLE: 4 beats each, alternating, no bubbles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      chk("tie_seq", 32'(y), ((i / 4) % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Backpressure: y holds 0x3C for 5 stalled cycles, then drain+refill.
    do_reset();
    step(1'b1, 8'h3C, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h3D, 1'b1, 8'h22, 1'b0);
      chk("bp_hold", 32'(y), 32'h3C);
    end
    step(1'b1, 8'h3D, 1'b1, 8'h22, 1'b1);
    chk("bp_refill", 32'(y), 32'h3D);

    // Owner drops after 2 beats while the other side waits.
    do_reset();
    step(1'b1, 8'h01, 1'b1, 8'h77, 1'b1);
    step(1'b1, 8'h02, 1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
    chk("drop_next", 32'(y), 32'h77);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h05, 1'b1, 8'h78, 1'b1);

    // Reset mid-burst in OWN1 with y pending; next tie goes to requester 0.
    do_reset();
    step(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h56, 1'b0);
    do_reset();
    chk("mid_rst_yv", 32'(y_valid), 32'd0);
    step(1'b1, 8'h99, 1'b1, 8'h66, 1'b1);
    chk("mid_rst_tie", 32'(y), 32'h99);

    // Stats: 6 beats from requester 0, then 3 from requester 1.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("stats0", 32'(cnt0), 32'(exp_cnt(6)));
    chk("stats1", 32'(cnt1), 32'(exp_cnt(3)));

    // Random traffic; requesters keep req/data stable until granted.
    do_reset();
    pr0 = 1'b0; pr1 = 1'b0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pr0 && $urandom_range(9) < 6) begin pr0 = 1'b1; pd0 = 8'($urandom); end
      if (!pr1 && $urandom_range(9) < 6) begin pr1 = 1'b1; pd1 = 8'($urandom); end
      if (i == 200) do_reset();
      step(pr0, pd0, pr1, pd1, $urandom_range(9) < 7);
      if (m_gnt == 0) begin pr0 = $urandom_range(1) == 1; pd0 = 8'($urandom); end
      if (m_gnt == 1) begin pr1 = $urandom_range(1) == 1; pd1 = 8'($urandom); end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
